// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: assembles N-bit words MSB- or LSB-first,
// delivers them with a Valid/Ack handshake and flags lost words (Overrun).
// Ports: Clock, Reset (async, active-low), SerialIn, BitValid, MsbFirst,
//   Ack, Clear (sync flush) in; Q, Valid, Overrun, Count, ParityErr out.
// Optional macro SHIFT_DESERIALIZER_PARITY_EN: expect a trailing even-parity
//   bit per word and report its check on ParityErr (tied 0 otherwise).
module shift_deserializer #(
   parameter int N = 4
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     SerialIn,
   input  logic                     BitValid,
   input  logic                     MsbFirst,
   input  logic                     Ack,
   input  logic                     Clear,
   output logic [N-1:0]             Q,
   output logic                     Valid,
   output logic                     Overrun,
   output logic [$clog2(N+1)-1:0]   Count,
   output logic                     ParityErr
);

   localparam int CW = $clog2(N+1);

`ifdef SHIFT_DESERIALIZER_PARITY_EN
   // Last accepted bit of a word is the parity bit at index N.
   localparam logic [CW-1:0] LAST = CW'(N);
`else
   localparam logic [CW-1:0] LAST = CW'(N-1);
`endif

   logic [N-1:0]  sr_q, sr_d;
   logic [N-1:0]  q_q, q_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          valid_q, valid_d;
   logic          ovr_q, ovr_d;
   logic          msb_q, msb_d;
   logic          dir;
   logic [N-1:0]  shifted;

`ifdef SHIFT_DESERIALIZER_PARITY_EN
   logic          par_q, par_d;
   logic          perr_q, perr_d;
`endif

   always_comb begin
      sr_d    = sr_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      msb_d   = msb_q;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
      par_d   = par_q;
      perr_d  = perr_q;
`endif
      // The first bit of a word uses the live MsbFirst so it shifts the
      // right way on the same edge that latches the direction.
      dir     = (cnt_q == '0) ? MsbFirst : msb_q;
      shifted = dir ? {sr_q[N-2:0], SerialIn}
                    : {SerialIn, sr_q[N-1:1]};

      if (Clear) begin
         sr_d    = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
         ovr_d   = 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
         par_d   = 1'b0;
         perr_d  = 1'b0;
`endif
      end else begin
         if (Ack && valid_q)
            valid_d = 1'b0;

         if (BitValid) begin
            if (cnt_q == '0)
               msb_d = MsbFirst;

            if (cnt_q == LAST) begin
               cnt_d   = '0;
               sr_d    = '0;
               valid_d = 1'b1;
               // A same-edge Ack consumes the old word, so nothing is lost.
               if (valid_q && !Ack)
                  ovr_d = 1'b1;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
               q_d     = sr_q;
               perr_d  = par_q ^ SerialIn;
               par_d   = 1'b0;
`else
               q_d     = shifted;
`endif
            end else begin
               cnt_d = cnt_q + CW'(1);
               sr_d  = shifted;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
               par_d = par_q ^ SerialIn;
`endif
            end
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         sr_q    <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         msb_q   <= 1'b1;
      end else begin
         sr_q    <= sr_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         msb_q   <= msb_d;
      end
   end

`ifdef SHIFT_DESERIALIZER_PARITY_EN
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         par_q  <= 1'b0;
         perr_q <= 1'b0;
      end else begin
         par_q  <= par_d;
         perr_q <= perr_d;
      end
   end

   assign ParityErr = perr_q;
`else
   assign ParityErr = 1'b0;
`endif

   assign Q       = q_q;
   assign Valid   = valid_q;
   assign Overrun = ovr_q;
   assign Count   = cnt_q;

endmodule

// File: doc/shift_deserializer.md
Name: shift_deserializer

Overview:
Serial-to-parallel receiver. It is the far end of the 4-bit universal shift register's serial shift-out path. It accepts one bit per qualified clock, assembles N-bit words MSB-first (left shift) or LSB-first (right shift), and presents each completed word on a parallel output. A Valid/Ack handshake delivers the word, and a sticky overrun flag records words that were lost.

Parameters:
N, 4, word width in bits (N >= 2)

Ports:
Clock  in  1  system clock; all state updates on rising edge
Reset  in  1  asynchronous, active-low; 0 forces all state to reset values immediately
SerialIn  in  1  serial data bit
BitValid  in  1  1 = SerialIn is sampled on this edge
MsbFirst  in  1  1 = left shift (first bit lands in Q[N-1]); 0 = right shift (first bit lands in Q[0])
Ack  in  1  consumer accepts the held word
Clear  in  1  synchronous abort/flush
Q  out  N  last completed word
Valid  out  1  Q holds an unacknowledged word
Overrun  out  1  sticky; a word completed while Valid=1 and Ack=0
Count  out  $clog2(N+1)  bits accepted in the current word
ParityErr  out  1  parity result for the word in Q (see Optional Feature)

Behaviour:
- Reset=0 (asynchronous): internal shift register, Q, Count, Valid, Overrun and ParityErr all go to 0. Latched direction goes to MSB-first.
- Priority on each rising edge: Reset, then Clear, then BitValid/Ack.
- Clear=1: shift register, Count, Valid, Overrun and ParityErr go to 0. Q holds its value. BitValid is ignored that cycle.
- Direction latch: MsbFirst is sampled only when Count==0 and BitValid=1, and is held for the rest of the word. Changes to MsbFirst mid-word have no effect.
- Bit acceptance (BitValid=1):
  - MSB-first: sr <= {sr[N-2:0], SerialIn}.
  - LSB-first: sr <= {SerialIn, sr[N-1:1]}.
  - Count increments by 1.
- Word completion: happens on the edge that accepts bit N (Count==N-1 and BitValid=1).
  - Q <= assembled word, including the bit accepted on that edge.
  - Valid <= 1 and Count <= 0, all on that same edge. Latency from last bit to Q/Valid is 0 extra cycles.
- Count never reaches N; the counter wraps directly from N-1 to 0.
- BitValid=0: shift register and Count hold. Gaps between bits of any length are allowed.
- Ack=1 with Valid=1 and no completion on that edge: Valid <= 0 on the next edge. Ack while Valid=0 is ignored.
- Completion and Ack on the same edge: the new word loads, Valid stays 1, and Overrun is unchanged.
- Completion while Valid=1 and Ack=0: Q is overwritten with the new word, Valid stays 1, Overrun <= 1. Overrun clears only on Clear or Reset.
- Reset or Clear mid-word discards all partial bits. The next word starts at Count=0.

Optional Feature:
Macro: SHIFT_DESERIALIZER_PARITY_EN

Defined:
- Each word is N data bits followed by one even-parity bit, accepted with BitValid like any other bit. Count then runs 0..N.
- The parity bit is not shifted into the shift register.
- Completion (Q, Valid, Count <= 0) happens on the edge that accepts the parity bit.
- ParityErr <= XOR of the N data bits and the parity bit, updated on that same edge, so ParityErr=1 means odd total ones.
- ParityErr holds until the next completion, Clear or Reset.

Undefined:
- No parity bit is expected; completion happens after bit N.
- ParityErr is tied to 0.

Test Plan:
- Reset low at mid-simulation, with Q=1101 and Valid=1 -> Q=0000, Valid=0, Overrun=0 and Count=0 immediately, without waiting for a clock edge.
- MsbFirst=1, bits 1,1,0,1 on consecutive edges -> Count steps 1,2,3,0, and Q=1101 with Valid=1 on the 4th edge. Ack=1 for one cycle -> Valid=0 on the next edge.
- MsbFirst=0, bits 1,0,0,1 with 2-cycle gaps between bits -> Q=1001. Then bits 1,1,0,0 -> Q=0011.
- Overrun case:
  - Load word 1101 and do not Ack, then send word 1001 -> Q=1001, Valid=1, Overrun=1.
  - Clear=1 -> Valid=0, Overrun=0, Q stays 1001.
  - Repeat with Ack asserted on the completing edge -> Overrun stays 0.
- Reset mid-word: send 2 bits (1,1), pulse Reset low, then send 0,1,1,0 MSB-first -> Q=0110, with no leftover bits from before the reset. Toggling MsbFirst after bit 1 leaves the result unchanged.
- With SHIFT_DESERIALIZER_PARITY_EN: send 1101 then parity bit 1 -> Q=1101, ParityErr=0. Send 1101 then parity bit 0 -> ParityErr=1. Valid asserts only on the 5th bit.
